// File: rtl/cu_sequencer.sv
// -----------------------------------------------------------------------------
// cu_sequencer -- multi-cycle instruction sequencer for the 8-bit datapath.
//
// Accepts one 32-bit instruction at a time from the instruction bus and
// latches it into the IR. It then steps through EXEC, an optional multiply
// wait (MUL), and a single write-back / PC-update cycle (WB). The sequencer
// drives the ALU/multiplier operands, the opcode and the start strobe, the
// write-back enable, and the program-counter controls.
//
// Parameters
//   MUL_CYCLES  execute cycles taken by MULTIPLY, EXEC included (1..31)
//   PC_W        program-counter / jump-target width
//
// Ports
//   clk            clock; all state updates on the rising edge
//   reset          synchronous, active-high
//   instr_valid    instruction bus holds a valid instruction
//   instruction    [7:0] opA, [15:8] opB, [20:16] opcode, [29:21] target
//   SREG           status flags {V,N,C,Z}
//   instr_ack      instruction accepted this cycle (only input-to-output path)
//   operand_a/b    latched operands
//   alu_opcode     latched opcode
//   alu_start      one-cycle start strobe to the ALU/multiplier
//   mul_busy       multiply in progress
//   wb_en          write the result register this cycle
//   hold           1 = PC holds, 0 = PC advances or jumps
//   jump_en        PC loads jump_line_num this cycle
//   jump_line_num  jump target (zero unless the IR holds a jump)
//   halted         sequencer stopped until reset
//   illegal_op     (CU_ILLEGAL_TRAP_EN only) undefined opcode trapped
//
// Build option
//   CU_ILLEGAL_TRAP_EN  when defined, an undefined opcode halts the sequencer
//                       and raises illegal_op; otherwise it retires as a NOP.
// -----------------------------------------------------------------------------
module cu_sequencer #(
   parameter int MUL_CYCLES = 8,
   parameter int PC_W       = 9
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic [31:0]     instruction,
   input  logic [3:0]      SREG,
   output logic            instr_ack,
   output logic [7:0]      operand_a,
   output logic [7:0]      operand_b,
   output logic [4:0]      alu_opcode,
   output logic            alu_start,
   output logic            mul_busy,
   output logic            wb_en,
   output logic            hold,
   output logic            jump_en,
   output logic [PC_W-1:0] jump_line_num,
`ifdef CU_ILLEGAL_TRAP_EN
   output logic            illegal_op,
`endif
   output logic            halted
);

   localparam logic [4:0] OP_MUL  = 5'h10;
   localparam logic [4:0] OP_JMP  = 5'h11;
   localparam logic [4:0] OP_JZ   = 5'h12;
   localparam logic [4:0] OP_JC   = 5'h13;
   localparam logic [4:0] OP_JN   = 5'h14;
   localparam logic [4:0] OP_JV   = 5'h15;
   localparam logic [4:0] OP_HALT = 5'h1F;

   // EXEC is the first of the MUL_CYCLES multiply cycles, so the MUL state
   // runs for MUL_CYCLES-1 cycles.
   localparam logic [4:0] CNT_INIT = 5'(MUL_CYCLES - 1);

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_MUL,
      S_WB,
      S_HALT
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [29:0] ir_q;
   logic [4:0]  cnt_q;
   logic        taken_q;
   logic [4:0]  op;

   // Bits [31:30] of the instruction word carry nothing for this sequencer.
   logic unused_ir_bits;
   assign unused_ir_bits = ^instruction[31:30];

   function automatic logic is_alu(input logic [4:0] o);
      return (o >= 5'h01) && (o <= 5'h0F);
   endfunction

   function automatic logic is_jump(input logic [4:0] o);
      return (o >= OP_JMP) && (o <= OP_JV);
   endfunction

`ifdef CU_ILLEGAL_TRAP_EN
   function automatic logic is_undef(input logic [4:0] o);
      return (o >= 5'h16) && (o <= 5'h1E);
   endfunction
`endif

   // Flag test for the jump family; SREG = {V,N,C,Z}.
   function automatic logic jump_cond(input logic [4:0] o, input logic [3:0] f);
      logic t;
      t = 1'b0;
      case (o)
         OP_JMP:  t = 1'b1;
         OP_JZ:   t = f[0];
         OP_JC:   t = f[1];
         OP_JN:   t = f[2];
         OP_JV:   t = f[3];
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   assign op = ir_q[20:16];

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // ---- IR, multiply counter and sampled jump condition ----
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q    <= '0;
         cnt_q   <= '0;
         taken_q <= 1'b0;
      end else begin
         if (state_q == S_FETCH && instr_valid) ir_q <= instruction[29:0];
         if (state_q == S_EXEC) begin
            taken_q <= jump_cond(op, SREG);
            cnt_q   <= CNT_INIT;
         end else if (state_q == S_MUL) begin
            cnt_q <= cnt_q - 5'd1;
         end
      end
   end

`ifdef CU_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (reset)                                    illegal_q <= 1'b0;
      else if (state_q == S_EXEC && is_undef(op))   illegal_q <= 1'b1;
   end
   assign illegal_op = illegal_q;
`endif

   // ---- next state and control outputs ----
   always_comb begin
      state_d   = state_q;
      hold      = 1'b1;
      instr_ack = 1'b0;
      alu_start = 1'b0;
      mul_busy  = 1'b0;
      wb_en     = 1'b0;
      jump_en   = 1'b0;
      halted    = 1'b0;
      case (state_q)
         S_FETCH: begin
            // Masked during reset so the bus never sees an acknowledge that
            // the reset is about to discard.
            instr_ack = instr_valid && !reset;
            if (instr_valid) state_d = S_EXEC;
         end
         S_EXEC: begin
            alu_start = is_alu(op) || (op == OP_MUL);
            if (op == OP_MUL)       state_d = (MUL_CYCLES == 1) ? S_WB : S_MUL;
            else if (op == OP_HALT) state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
            else if (is_undef(op))  state_d = S_HALT;
`endif
            else                    state_d = S_WB;
         end
         S_MUL: begin
            mul_busy = 1'b1;
            if (cnt_q <= 5'd1) state_d = S_WB;
         end
         S_WB: begin
            hold    = 1'b0;
            wb_en   = is_alu(op) || (op == OP_MUL);
            jump_en = taken_q;
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign operand_a     = ir_q[7:0];
   assign operand_b     = ir_q[15:8];
   assign alu_opcode    = op;
   assign jump_line_num = is_jump(op) ? PC_W'(ir_q[29:21]) : '0;

endmodule

// File: tb/tb_cu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cu_sequencer -- randomized bench for cu_sequencer.
// A transaction-level model tracks the instruction in flight by its age
// (cycles since acceptance) and derives each cycle's expected outputs from the
// sequencing rules. Random resets, including mid-multiply, and forced resets
// out of HALT are applied along the way.
// -----------------------------------------------------------------------------
module tb_cu_sequencer;

   localparam int MUL_CYCLES = 8;
   localparam int PC_W       = 9;
   localparam int N_CYCLES   = 4000;

   logic            clk = 1'b0;
   logic            reset;
   logic            instr_valid;
   logic [31:0]     instruction;
   logic [3:0]      SREG;
   logic            instr_ack;
   logic [7:0]      operand_a;
   logic [7:0]      operand_b;
   logic [4:0]      alu_opcode;
   logic            alu_start;
   logic            mul_busy;
   logic            wb_en;
   logic            hold;
   logic            jump_en;
   logic [PC_W-1:0] jump_line_num;
   logic            halted;
`ifdef CU_ILLEGAL_TRAP_EN
   logic            illegal_op;
`endif

   cu_sequencer #(.MUL_CYCLES(MUL_CYCLES), .PC_W(PC_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .instr_valid   (instr_valid),
      .instruction   (instruction),
      .SREG          (SREG),
      .instr_ack     (instr_ack),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .alu_opcode    (alu_opcode),
      .alu_start     (alu_start),
      .mul_busy      (mul_busy),
      .wb_en         (wb_en),
      .hold          (hold),
      .jump_en       (jump_en),
      .jump_line_num (jump_line_num),
`ifdef CU_ILLEGAL_TRAP_EN
      .illegal_op    (illegal_op),
`endif
      .halted        (halted)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
      end
   endtask

   // ---- reference model state ----
   bit          m_busy, m_halted, m_illegal, m_taken;
   int          m_age;
   logic [31:0] m_ir;
   int          halt_cnt;

   function automatic int wb_age(input int o);
      return (o == 16) ? 1 + MUL_CYCLES : 2;
   endfunction

   function automatic bit writes_back(input int o);
      return (o >= 1) && (o <= 16);
   endfunction

   function automatic bit flag_taken(input int o, input logic [3:0] f);
      case (o)
         17:      return 1'b1;
         18:      return f[0];
         19:      return f[1];
         20:      return f[2];
         21:      return f[3];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      int r;
      int o;
      w = $urandom;
      r = $urandom_range(0, 99);
      if      (r < 40) o = $urandom_range(1, 15);
      else if (r < 48) o = 0;
      else if (r < 64) o = 16;
      else if (r < 88) o = $urandom_range(17, 21);
      else if (r < 95) o = $urandom_range(22, 30);
      else             o = 31;
      w[20:16] = 5'(o);
      return w;
   endfunction

   task automatic model_clear();
      m_busy    = 0;
      m_halted  = 0;
      m_illegal = 0;
      m_taken   = 0;
      m_age     = 0;
      m_ir      = '0;
      halt_cnt  = 0;
   endtask

   initial begin
      bit e_hold, e_ack, e_start, e_busy, e_wb, e_jen, e_halt;
      logic [31:0] e_jln;
      int op;

      reset       = 1'b1;
      instr_valid = 1'b0;
      instruction = '0;
      SREG        = '0;
      model_clear();
      repeat (2) @(posedge clk);

      for (int c = 0; c < N_CYCLES; c++) begin
         cyc = c;
         @(negedge clk);
         reset       = (halt_cnt > 4) || ($urandom_range(0, 79) == 0);
         instr_valid = ($urandom_range(0, 3) != 0);
         instruction = gen_instr();
         SREG        = 4'($urandom);
         #1;

         // Expected outputs for this cycle, from the instruction's age.
         op      = int'(m_ir[20:16]);
         e_hold  = 1; e_ack = 0; e_start = 0; e_busy = 0;
         e_wb    = 0; e_jen = 0; e_halt  = 0;
         if (m_halted) begin
            e_halt = 1;
         end else if (!m_busy) begin
            e_ack = instr_valid && !reset;
         end else begin
            if (m_age == 1) e_start = writes_back(op);
            if (op == 16 && m_age >= 2 && m_age < wb_age(op)) e_busy = 1;
            if (m_age == wb_age(op)) begin
               e_hold = 0;
               e_wb   = writes_back(op);
               e_jen  = m_taken;
            end
         end
         e_jln = (op >= 17 && op <= 21) ? {23'd0, m_ir[29:21]} : 32'd0;

         check_eq("instr_ack",     instr_ack,     e_ack);
         check_eq("hold",          hold,          e_hold);
         check_eq("alu_start",     alu_start,     e_start);
         check_eq("mul_busy",      mul_busy,      e_busy);
         check_eq("wb_en",         wb_en,         e_wb);
         check_eq("jump_en",       jump_en,       e_jen);
         check_eq("jump_line_num", jump_line_num, e_jln);
         check_eq("halted",        halted,        e_halt);
         check_eq("operand_a",     operand_a,     m_ir[7:0]);
         check_eq("operand_b",     operand_b,     m_ir[15:8]);
         check_eq("alu_opcode",    alu_opcode,    m_ir[20:16]);
`ifdef CU_ILLEGAL_TRAP_EN
         check_eq("illegal_op",    illegal_op,    m_illegal);
`endif

         @(posedge clk);
         // Advance the model by one clock using the inputs just applied.
         if (reset) begin
            model_clear();
         end else if (m_halted) begin
            halt_cnt++;
         end else if (!m_busy) begin
            if (instr_valid) begin
               m_busy = 1;
               m_age  = 1;
               m_ir   = instruction;
            end
         end else begin
            if (m_age == 1) begin
               m_taken = flag_taken(op, SREG);
               if (op == 31) begin
                  m_halted = 1;
                  m_busy   = 0;
               end
`ifdef CU_ILLEGAL_TRAP_EN
               if (op >= 22 && op <= 30) begin
                  m_halted  = 1;
                  m_illegal = 1;
                  m_busy    = 0;
               end
`endif
            end
            if (m_busy) begin
               if (m_age == wb_age(op)) m_busy = 0;
               else                     m_age++;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Multi-cycle instruction sequencer for the 8-bit datapath. Accepts one 32-bit instruction at a time and decodes it.
- Drives the ALU/multiplier operands, opcode and start strobe, and the write-back enable.
- Controls the program counter through hold/jump_en/jump_line_num. Multiply occupies MUL_CYCLES execute cycles; the PC is stalled until retire.

Parameters:
- MUL_CYCLES, 8, execute cycles for MULTIPLY (legal 1..31)
- PC_W, 9, program-counter / jump-target width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instruction bus holds a valid instruction
- instruction  in  32  [7:0] operand A, [15:8] operand B, [20:16] opcode, [29:21] jump target, [31:30] ignored
- SREG  in  4  status flags {V,N,C,Z} = SREG[3:0]
- instr_ack  out  1  instruction accepted this cycle
- operand_a  out  8  latched operand A
- operand_b  out  8  latched operand B
- alu_opcode  out  5  latched opcode
- alu_start  out  1  one-cycle start strobe to ALU/multiplier
- mul_busy  out  1  multiply in progress
- wb_en  out  1  write result register this cycle
- hold  out  1  1 = PC holds; 0 = PC advances (or jumps)
- jump_en  out  1  PC loads jump_line_num this cycle
- jump_line_num  out  PC_W  jump target
- halted  out  1  sequencer stopped

Behaviour:
- Opcode map:
  - 0x00 NOP
  - 0x01-0x0F single-cycle ALU
  - 0x10 MULTIPLY
  - 0x11 JMP
  - 0x12 JZ (Z)
  - 0x13 JC (C)
  - 0x14 JN (N)
  - 0x15 JV (V)
  - 0x1F HALT
  - 0x16-0x1E undefined
- States: FETCH, EXEC, MUL, WB, HALT. Registered IR holds the instruction. All outputs decode from the state, IR and counter registers only; no combinational input-to-output path except instr_ack.
- Reset:
  - Enters FETCH, IR=0, counter=0.
  - Outputs during/after reset: hold=1; instr_ack, alu_start, mul_busy, wb_en, jump_en, halted = 0; operand_a, operand_b, alu_opcode, jump_line_num = 0.
  - Reset in any state, including mid-multiply, aborts the instruction with no wb_en/jump_en.
- FETCH:
  - hold=1, instr_ack=instr_valid.
  - On instr_valid, latch instruction into IR and go to EXEC. Otherwise stay.
- EXEC (exactly 1 cycle):
  - alu_start=1 for ALU and MULTIPLY opcodes only. hold=1. SREG is sampled here for conditional jumps.
  - ALU/NOP/jumps -> WB.
  - MULTIPLY -> MUL, counter loaded with MUL_CYCLES-1. If MUL_CYCLES=1, go directly to WB.
  - HALT -> HALT.
  - Undefined opcode -> WB as NOP (see Optional Feature).
- MUL:
  - mul_busy=1, hold=1. Counter decrements each cycle; at counter==1 the next state is WB.
  - Total EXEC+MUL cycles = MUL_CYCLES.
- WB (exactly 1 cycle):
  - hold=0.
  - wb_en=1 for ALU and MULTIPLY.
  - jump_en=1 and jump_line_num=IR[29:21] for JMP, or for a Jcc whose sampled flag was 1.
  - Untaken jump: jump_en=0 and the PC simply advances.
  - Next state FETCH.
- jump_line_num holds IR[29:21] whenever IR holds a jump, else 0. jump_en is only ever high in WB.
- operand_a, operand_b and alu_opcode are stable from EXEC through WB.
- HALT: hold=1, halted=1, instr_ack=0. Sticky until reset.
- Latency: accepting in cycle t gives EXEC at t+1 and WB at t+2 (ALU/jump/NOP), or WB at t+1+MUL_CYCLES (multiply). Throughput is one instruction per 3 cycles minimum.
- instr_valid is ignored outside FETCH; no instruction is accepted while busy.

Optional Feature:
- Macro CU_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in EXEC goes to HALT. Adds output illegal_op (1 bit), set in that cycle and sticky with halted until reset.
- Undefined: an undefined opcode retires as NOP and the illegal_op port does not exist.

Test Plan:
- ALU op: accept instruction 0x0003_3412 (opA 0x12, opB 0x34, opcode 0x03) at t -> alu_start at t+1 with operand_a=0x12, operand_b=0x34, alu_opcode=0x03; wb_en=1 and hold=0 at t+2; hold=1 at all other cycles.
- Multiply, MUL_CYCLES=8: accept opcode 0x10 at t -> mul_busy=1 from t+2 to t+8; wb_en=1 and hold=0 only at t+9; instr_valid held high during t+1..t+8 -> instr_ack=0.
- Conditional jump: JZ with target 0x1A5 and SREG=0001 sampled in EXEC -> jump_en=1, jump_line_num=0x1A5 in WB. Same instruction with SREG=1110 -> jump_en=0, hold=0 in WB.
- Reset mid-multiply: assert reset in the 4th MUL cycle -> next cycle is FETCH with hold=1; no wb_en or jump_en is ever asserted for the aborted instruction.
- HALT (opcode 0x1F) -> halted=1 from t+2 onward, instr_ack stays 0, instructions ignored; reset clears halted.
- Opcode 0x18: with CU_ILLEGAL_TRAP_EN -> halted=1 and illegal_op=1 from t+2. Without it -> WB at t+2 with wb_en=0, jump_en=0, hold=0.
